// File: rtl/cont_sel_if.sv
// Button/selector bundle for cont_sel: debounced buttons and enable in, index and event pulses out.
interface cont_sel_if #(
  parameter int N_POS = 3
);
  localparam int W = $clog2(N_POS);

  logic         der_i;
  logic         izq_i;
  logic         en_i;
  logic [W-1:0] dir_o;
  logic         moved_o;
  logic         wrapped_o;
  logic         limit_o;

  modport master (
    output der_i, izq_i, en_i,
    input  dir_o, moved_o, wrapped_o, limit_o
  );

  modport slave (
    input  der_i, izq_i, en_i,
    output dir_o, moved_o, wrapped_o, limit_o
  );
endinterface

// File: rtl/cont_sel.sv
// Cursor/selector counter over 0..N_POS-1 stepped by debounced left/right presses.
// Define CONT_SEL_REPEAT_EN to build the hold-to-repeat FSM and its counters.
module cont_sel #(
  parameter int N_POS    = 3,
  parameter bit WRAP     = 1'b1,
  parameter int HOLD_CYC = 50_000_000,
  parameter int REP_CYC  = 10_000_000
) (
  input  logic      clk,
  input  logic      reset,
  cont_sel_if.slave bus
);
  localparam int           W    = $clog2(N_POS);
  localparam logic [W-1:0] LAST = W'(N_POS - 1);

  if (N_POS < 2 || N_POS > 256 || HOLD_CYC < 2 || REP_CYC < 1) begin : g_bad_param
    $error("cont_sel: parameter out of range");
  end

  logic         der_q, izq_q;
  logic         press_r, press_l;
  logic         step_r, step_l;
  logic [W-1:0] dir_q, dir_d;
  logic         moved_q, moved_d;
  logic         wrapped_q, wrapped_d;
  logic         limit_q, limit_d;

  assign press_r = bus.der_i & ~der_q;
  assign press_l = bus.izq_i & ~izq_q;

`ifdef CONT_SEL_REPEAT_EN
  localparam int            MAX_C  = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
  localparam int            CW     = $clog2(MAX_C + 1);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD_CYC);
  localparam logic [CW-1:0] REP_C  = CW'(REP_CYC);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hold_r_q, hold_r_d;
  logic          both, held_same, due;

  // Both-high is handled first everywhere, so only the tracked button matters here.
  assign both      = bus.der_i & bus.izq_i;
  assign held_same = hold_r_q ? bus.der_i : bus.izq_i;
  assign due       = (state_q == S_HOLD) ? (cnt_q == HOLD_C) : (cnt_q == REP_C);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hold_r_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_r_q <= hold_r_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!bus.en_i || both) begin
      state_d = S_IDLE;
    end else if (press_r || press_l) begin
      state_d = S_HOLD;
    end else if (state_q != S_IDLE) begin
      if (!held_same) state_d = S_IDLE;
      else if (due)   state_d = S_REPEAT;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one unassigned (no latch).
    step_r   = 1'b0;
    step_l   = 1'b0;
    cnt_d    = '0;
    hold_r_d = hold_r_q;
    if (bus.en_i && !both) begin
      if (press_r || press_l) begin
        step_r   = press_r;
        step_l   = press_l;
        cnt_d    = CW'(1);
        hold_r_d = press_r;
      end else if (state_q != S_IDLE && held_same) begin
        if (due) begin
          step_r = hold_r_q;
          step_l = ~hold_r_q;
          cnt_d  = CW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end
`else
  assign step_r = bus.en_i & press_r & ~bus.izq_i;
  assign step_l = bus.en_i & press_l & ~bus.der_i;
`endif

  always_comb begin
    dir_d     = dir_q;
    moved_d   = 1'b0;
    wrapped_d = 1'b0;
    limit_d   = 1'b0;
    if (!bus.en_i) begin
      dir_d = '0;
    end else if (step_r) begin
      if (dir_q == LAST) begin
        if (WRAP) begin
          dir_d     = '0;
          moved_d   = 1'b1;
          wrapped_d = 1'b1;
        end else begin
          limit_d = 1'b1;
        end
      end else begin
        dir_d   = dir_q + W'(1);
        moved_d = 1'b1;
      end
    end else if (step_l) begin
      if (dir_q == '0) begin
        if (WRAP) begin
          dir_d     = LAST;
          moved_d   = 1'b1;
          wrapped_d = 1'b1;
        end else begin
          limit_d = 1'b1;
        end
      end else begin
        dir_d   = dir_q - W'(1);
        moved_d = 1'b1;
      end
    end
  end

  // Edge registers track the buttons even while disabled, so a held button cannot step on enable.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      der_q     <= 1'b0;
      izq_q     <= 1'b0;
      dir_q     <= '0;
      moved_q   <= 1'b0;
      wrapped_q <= 1'b0;
      limit_q   <= 1'b0;
    end else begin
      der_q     <= bus.der_i;
      izq_q     <= bus.izq_i;
      dir_q     <= dir_d;
      moved_q   <= moved_d;
      wrapped_q <= wrapped_d;
      limit_q   <= limit_d;
    end
  end

  assign bus.dir_o     = dir_q;
  assign bus.moved_o   = moved_q;
  assign bus.wrapped_o = wrapped_q;
  assign bus.limit_o   = limit_q;
endmodule
